mem_port_arbiter: RTL and testbench

//  Shares one external-memory command/write/read FIFO channel set among NUM_PORTS requesters
//  (e.g. DAC playback and ADC record engines). Sits between the requesters and the MIG adapter.

---
 rtl/mem_pkg.sv | 20 ++
 rtl/rr_picker.sv | 27 ++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the external-memory channel: command word layout and arbiter FSM states.
package mem_pkg;

    localparam int MEM_DATA_WIDTH = 32;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] length;
        logic        read_not_write;
    } MemoryCommand;

    localparam int CMD_W = $bits(MemoryCommand);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set bit of req starting just after 'last', wrapping.
module rr_picker #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          found,
    output logic [IW-1:0] idx
);

    int cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last) + k) % N;
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one MIG command/write/read channel set among NUM_PORTS requesters.
// A grant covers one whole command, including every data beat, before the next decision.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter  int NUM_PORTS  = 4,
    parameter  int DATA_WIDTH = MEM_DATA_WIDTH,
    localparam int GW         = $clog2(NUM_PORTS)
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [NUM_PORTS-1:0]                 req_cmd_valid,
    output logic [NUM_PORTS-1:0]                 req_cmd_ready,
    input  logic [NUM_PORTS-1:0][CMD_W-1:0]      req_cmd_data,
    input  logic [NUM_PORTS-1:0]                 req_wr_valid,
    output logic [NUM_PORTS-1:0]                 req_wr_ready,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] req_wr_data,
    output logic [NUM_PORTS-1:0]                 req_rd_valid,
    input  logic [NUM_PORTS-1:0]                 req_rd_ready,
    output logic [DATA_WIDTH-1:0]                req_rd_data,
    output logic                                 mem_cmd_valid,
    input  logic                                 mem_cmd_ready,
    output logic [CMD_W-1:0]                     mem_cmd_data,
    output logic                                 mem_wr_valid,
    input  logic                                 mem_wr_ready,
    output logic [DATA_WIDTH-1:0]                mem_wr_data,
    input  logic                                 mem_rd_valid,
    output logic                                 mem_rd_ready,
    input  logic [DATA_WIDTH-1:0]                mem_rd_data,
    output logic [GW-1:0]                        grant_id,
    output logic                                 busy
);

    arb_state_e   state_q, state_d;
    logic [GW-1:0] rr_last_q, rr_last_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    MemoryCommand cur_cmd_q, cur_cmd_d;
    logic [31:0]  beat_cnt_q, beat_cnt_d;

    logic                 pick_found;
    logic [GW-1:0]        pick_idx;
    logic [NUM_PORTS-1:0] cmd_ready_c;
    logic                 beat;

    rr_picker #(.N(NUM_PORTS)) u_rr_picker (
        .req   (req_cmd_valid),
        .last  (rr_last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rr_last_q  <= GW'(NUM_PORTS - 1);
            grant_id_q <= '0;
            cur_cmd_q  <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_last_q  <= rr_last_d;
            grant_id_q <= grant_id_d;
            cur_cmd_q  <= cur_cmd_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        grant_id_d    = grant_id_q;
        cur_cmd_d     = cur_cmd_q;
        beat_cnt_d    = beat_cnt_q;
        cmd_ready_c   = '0;
        mem_cmd_valid = 1'b0;
        mem_wr_valid  = 1'b0;
        mem_wr_data   = '0;
        req_wr_ready  = '0;
        req_rd_valid  = '0;
        mem_rd_ready  = 1'b0;
        beat          = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ready is only raised for the winner, so the handshake is implied by pick_found.
                if (pick_found) begin
                    cmd_ready_c[pick_idx] = 1'b1;
                    cur_cmd_d             = MemoryCommand'(req_cmd_data[pick_idx]);
                    grant_id_d            = pick_idx;
                    beat_cnt_d            = '0;
                    state_d               = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                mem_cmd_valid = 1'b1;
                if (mem_cmd_ready) begin
                    if (cur_cmd_q.length != 32'd0) begin
                        state_d = ST_XFER;
                    end else begin
                        state_d   = ST_IDLE;
                        rr_last_d = grant_id_q;
                    end
                end
            end
            ST_XFER: begin
                if (!cur_cmd_q.read_not_write) begin
                    mem_wr_valid             = req_wr_valid[grant_id_q];
                    mem_wr_data              = req_wr_data[grant_id_q];
                    req_wr_ready[grant_id_q] = mem_wr_ready;
                    beat                     = req_wr_valid[grant_id_q] && mem_wr_ready;
                end else begin
                    req_rd_valid[grant_id_q] = mem_rd_valid;
                    mem_rd_ready             = req_rd_ready[grant_id_q];
                    beat                     = mem_rd_valid && req_rd_ready[grant_id_q];
                end
                if (beat) begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                    if (beat_cnt_q == cur_cmd_q.length - 32'd1) begin
                        state_d   = ST_IDLE;
                        rr_last_d = grant_id_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Gate with reset so no requester sees a ready pulse while the block is held in reset.
    assign req_cmd_ready = cmd_ready_c & {NUM_PORTS{reset}};
    assign mem_cmd_data  = cur_cmd_q;
    assign req_rd_data   = mem_rd_data;
    assign grant_id      = grant_id_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, round-robin order, read/write beats, stalls, reset.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [3:0]            req_cmd_valid, req_cmd_ready;
    logic [3:0][CMD_W-1:0] req_cmd_data;
    logic [3:0]            req_wr_valid, req_wr_ready;
    logic [3:0][31:0]      req_wr_data;
    logic [3:0]            req_rd_valid, req_rd_ready;
    logic [31:0]           req_rd_data;
    logic                  mem_cmd_valid, mem_cmd_ready;
    logic [CMD_W-1:0]      mem_cmd_data;
    logic                  mem_wr_valid, mem_wr_ready;
    logic [31:0]           mem_wr_data;
    logic                  mem_rd_valid, mem_rd_ready;
    logic [31:0]           mem_rd_data;
    logic [1:0]            grant_id;
    logic                  busy;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .req_cmd_valid(req_cmd_valid), .req_cmd_ready(req_cmd_ready), .req_cmd_data(req_cmd_data),
        .req_wr_valid(req_wr_valid), .req_wr_ready(req_wr_ready), .req_wr_data(req_wr_data),
        .req_rd_valid(req_rd_valid), .req_rd_ready(req_rd_ready), .req_rd_data(req_rd_data),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_data(mem_cmd_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_data(mem_wr_data),
        .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rd_data(mem_rd_data),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [CMD_W-1:0] mk(input logic [31:0] a, input logic [31:0] l, input logic r);
        return {a, l, r};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present vec, expect port p to win, then complete the command handshake.
    task automatic arb(input logic [3:0] vec, input int p);
        logic [3:0] oh;
        oh = 4'b0001 << p;
        req_cmd_valid = vec;
        #1;
        chk("arb_ready", req_cmd_ready, oh);
        @(negedge clk);
        req_cmd_valid = vec & ~oh;
        #1;
        chk("arb_grant", grant_id, p[1:0]);
        chk("arb_cmd_valid", mem_cmd_valid, 1);
        chk("arb_cmd_data", mem_cmd_data, req_cmd_data[p]);
        chk("arb_no_ready_in_issue", req_cmd_ready, 0);
        chk("arb_busy", busy, 1);
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        #1;
    endtask

    // n write beats from port p (all ports offering data), one stall cycle before beat 1.
    task automatic wr_beats(input int p, input int n, input logic [31:0] base);
        logic [3:0] oh;
        oh = 4'b0001 << p;
        for (int i = 0; i < n; i++) begin
            req_wr_valid   = 4'b1111;
            req_wr_data[p] = base + i;
            if (i == 1) begin
                mem_wr_ready = 1'b0;
                #1;
                chk("wr_stall_ready", req_wr_ready, 0);
                chk("wr_stall_valid", mem_wr_valid, 1);
                @(negedge clk);
            end
            mem_wr_ready = 1'b1;
            #1;
            chk("wr_valid", mem_wr_valid, 1);
            chk("wr_data", mem_wr_data, base + i);
            chk("wr_ready_onehot", req_wr_ready, oh);
            chk("wr_no_cmd_ready", req_cmd_ready, 0);
            chk("wr_busy", busy, 1);
            @(negedge clk);
        end
    endtask

    initial begin
        int beats;
        int cyc;
        reset         = 1'b0;
        req_cmd_valid = 4'b1111;
        req_cmd_data  = '0;
        req_wr_valid  = '0;
        req_rd_ready  = '0;
        mem_cmd_ready = 1'b0;
        mem_wr_ready  = 1'b0;
        mem_rd_valid  = 1'b0;
        mem_rd_data   = 32'h0;
        for (int k = 0; k < 4; k++) req_wr_data[k] = 32'hBAD0 + k;

        // Reset state, with requests pending
        #2;
        chk("rst_cmd_ready", req_cmd_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant_id, 0);
        chk("rst_mem_cmd_valid", mem_cmd_valid, 0);
        chk("rst_mem_cmd_data", mem_cmd_data, 0);
        chk("rst_mem_wr_valid", mem_wr_valid, 0);
        chk("rst_mem_rd_ready", mem_rd_ready, 0);
        req_cmd_valid = '0;
        @(negedge clk);
        reset = 1'b1;

        // 1: port 1 writes 4 beats @0x10
        req_cmd_data[1] = mk(32'h10, 32'd4, 1'b0);
        arb(4'b0010, 1);
        chk("t1_wait_wr_valid", mem_wr_valid, 0);
        wr_beats(1, 4, 32'hA0);
        #1;
        chk("t1_busy_done", busy, 0);
        chk("t1_idle_wr_valid", mem_wr_valid, 0);
        chk("t1_idle_wr_ready", req_wr_ready, 0);
        req_wr_valid = '0;
        mem_wr_ready = 1'b0;

        // 2: round-robin between 0 and 2 after a fresh reset, then wrap cases
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req_cmd_data[0] = mk(32'h200, 32'd0, 1'b0);
        req_cmd_data[1] = mk(32'h100, 32'd0, 1'b0);
        req_cmd_data[2] = mk(32'h300, 32'd0, 1'b1);
        req_cmd_data[3] = mk(32'h3000, 32'd0, 1'b1);
        arb(4'b0101, 0);
        chk("t2_busy_a", busy, 0);
        arb(4'b0101, 2);
        chk("t2_busy_b", busy, 0);
        arb(4'b0101, 0);
        arb(4'b1010, 1);
        arb(4'b1011, 3);
        req_cmd_valid = '0;

        // 4: zero-length command on port 2 moves no data
        req_cmd_data[2] = mk(32'h2222_0000, 32'd0, 1'b0);
        req_wr_valid    = 4'b0100;
        mem_wr_ready    = 1'b1;
        arb(4'b0100, 2);
        chk("t4_busy", busy, 0);
        chk("t4_mem_cmd_valid", mem_cmd_valid, 0);
        chk("t4_wr_valid", mem_wr_valid, 0);
        chk("t4_wr_ready", req_wr_ready, 0);
        req_wr_valid = '0;
        mem_wr_ready = 1'b0;

        // 3: port 3 reads 300 beats with random source/sink stalls
        req_cmd_data[3] = mk(32'h4000, 32'd300, 1'b1);
        arb(4'b1000, 3);
        beats = 0;
        cyc   = 0;
        while (beats < 300 && cyc < 5000) begin
            mem_rd_valid = 1'($urandom_range(0, 1));
            mem_rd_data  = $urandom;
            req_rd_ready = 4'($urandom);
            #1;
            chk("t3_busy", busy, 1);
            chk("t3_rd_valid", req_rd_valid, {mem_rd_valid, 3'b000});
            chk("t3_rd_ready", mem_rd_ready, req_rd_ready[3]);
            chk("t3_rd_data", req_rd_data, mem_rd_data);
            if (mem_rd_valid && req_rd_ready[3]) beats++;
            cyc++;
            @(negedge clk);
        end
        chk("t3_no_timeout", (cyc < 5000), 1);
        mem_rd_valid = 1'b1;
        req_rd_ready = 4'b1111;
        #1;
        chk("t3_busy_done", busy, 0);
        chk("t3_idle_rd_valid", req_rd_valid, 0);
        chk("t3_idle_rd_ready", mem_rd_ready, 0);
        mem_rd_valid = 1'b0;
        req_rd_ready = '0;

        // 5: mem_cmd_ready held low; command stable, others wait for IDLE
        req_cmd_data[1] = mk(32'hDEAD0, 32'd2, 1'b0);
        req_cmd_valid   = 4'b0010;
        #1;
        chk("t5_ready", req_cmd_ready, 4'b0010);
        @(negedge clk);
        req_cmd_valid = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t5_cmd_valid", mem_cmd_valid, 1);
            chk("t5_cmd_stable", mem_cmd_data, mk(32'hDEAD0, 32'd2, 1'b0));
            chk("t5_no_cmd_ready", req_cmd_ready, 0);
            @(negedge clk);
        end
        mem_cmd_ready = 1'b1;
        @(negedge clk);
        mem_cmd_ready = 1'b0;
        wr_beats(1, 2, 32'hC0);
        #1;
        chk("t5_next_winner", req_cmd_ready, 4'b0100);
        req_cmd_valid = '0;
        req_wr_valid  = '0;
        mem_wr_ready  = 1'b0;
        @(negedge clk);

        // 6: reset during beat 2 of an 8-beat write
        req_cmd_data[0] = mk(32'h800, 32'd8, 1'b0);
        arb(4'b0001, 0);
        wr_beats(0, 2, 32'hE0);
        req_wr_valid   = 4'b0001;
        req_wr_data[0] = 32'hE2;
        mem_wr_ready   = 1'b1;
        #1;
        chk("t6_mid_beat", mem_wr_valid, 1);
        reset         = 1'b0;
        req_cmd_valid = 4'b0010;
        mem_rd_valid  = 1'b1;
        req_rd_ready  = 4'b1111;
        mem_cmd_ready = 1'b1;
        #1;
        chk("t6_cmd_ready", req_cmd_ready, 0);
        chk("t6_wr_ready", req_wr_ready, 0);
        chk("t6_rd_valid", req_rd_valid, 0);
        chk("t6_mem_cmd_valid", mem_cmd_valid, 0);
        chk("t6_mem_wr_valid", mem_wr_valid, 0);
        chk("t6_mem_rd_ready", mem_rd_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_grant", grant_id, 0);
        @(negedge clk);
        reset         = 1'b1;
        mem_rd_valid  = 1'b0;
        req_rd_ready  = '0;
        mem_cmd_ready = 1'b0;
        req_wr_valid  = '0;
        mem_wr_ready  = 1'b0;
        req_cmd_data[0] = mk(32'h900, 32'd0, 1'b1);
        arb(4'b0011, 0);
        req_cmd_valid = '0;
        chk("t6_busy_end", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
